// File: rtl/aes_kexp_pkg.sv
// Shared definitions for the key-expansion sequencer.
//   state_t    : sequencer states
//   kexp_step  : one step of the 4-word XOR chain on zero-extended words
package aes_kexp_pkg;

    localparam int WORD_W_DEF = 4;
    localparam int ROUNDS_DEF = 10;

    // Widest word the shared step function handles; narrower words are
    // zero-extended, which is harmless because the chain is purely bitwise.
    localparam int KEXP_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [3:0][KEXP_MAX_W-1:0] kexp_words_t;

    // Index 3 holds w0 (MS word), index 0 holds w3 (LS word).
    function automatic kexp_words_t kexp_step(input kexp_words_t w);
        kexp_words_t r;
        r[3] = w[3];
        r[2] = w[3] ^ w[2];
        r[1] = r[2] ^ w[1];
        r[0] = r[1] ^ w[0];
        return r;
    endfunction

endpackage

// File: rtl/aes_kexp_step_reg.sv
// Key word register with XOR-chain expansion step.
//   clk, rst : clock, synchronous active-high reset (clears all words)
//   load     : capture key into w0..w3
//   step     : replace w0..w3 with one expansion step (ignored when load)
//   key      : {w0,w1,w2,w3} source for load
//   words    : current {w0,w1,w2,w3}
module aes_kexp_step_reg
    import aes_kexp_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [4*WORD_W-1:0]   key,
    output logic [4*WORD_W-1:0]   words
);

    logic [3:0][WORD_W-1:0] w_q;
    logic [3:0][WORD_W-1:0] w_step;
    kexp_words_t            ext;
    kexp_words_t            ext_step;

    always_comb begin
        ext = '0;
        for (int i = 0; i < 4; i++) begin
            ext[i][WORD_W-1:0] = w_q[i];
        end
        ext_step = kexp_step(ext);
        for (int i = 0; i < 4; i++) begin
            w_step[i] = ext_step[i][WORD_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q <= '0;
        end else if (load) begin
            w_q <= key;
        end else if (step) begin
            w_q <= w_step;
        end
    end

    assign words = w_q;

endmodule

// File: rtl/aes_kexp_seq.sv
// Key-expansion sequencer: accepts a key, emits round 0..ROUNDS round keys
// over a valid/ready interface with full backpressure, then pulses done.
//   clk, rst                 : clock, synchronous active-high reset
//   start_valid/start_ready  : key load handshake (ready only in IDLE)
//   key                      : {w0,w1,w2,w3}, w0 = MS word
//   abort                    : cancel current sequence
//   rk_valid/rk_ready        : round key handshake
//   rk_data, rk_round        : round key and its index
//   busy                     : sequence in progress (EMIT or DONE)
//   done                     : one-cycle pulse after the last beat
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | waiting for a key, start_ready=1
// ST_EMIT | presenting round key rnd, waiting for rk_ready
// ST_DONE | last beat taken, done pulse, returns to IDLE
module aes_kexp_seq
    import aes_kexp_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int ROUNDS = ROUNDS_DEF,
    parameter int RND_W  = $clog2(ROUNDS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [4*WORD_W-1:0] key,
    input  logic                abort,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [4*WORD_W-1:0] rk_data,
    output logic [RND_W-1:0]    rk_round,
    output logic                busy,
    output logic                done
);

    state_t           state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic             load, step;

    aes_kexp_step_reg #(.WORD_W(WORD_W)) u_step_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .key   (key),
        .words (rk_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // start beats abort here: abort has no meaning in IDLE
                if (start_valid) begin
                    load    = 1'b1;
                    rnd_d   = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rk_ready) begin
                    // last-round check comes first so the counter never wraps
                    if (rnd_q == RND_W'(ROUNDS)) begin
                        state_d = ST_DONE;
                    end else begin
                        step  = 1'b1;
                        rnd_d = rnd_q + RND_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign start_ready = (state_q == ST_IDLE);
    assign rk_valid    = (state_q == ST_EMIT);
    assign busy        = (state_q == ST_EMIT) || (state_q == ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign rk_round    = rnd_q;

endmodule

// File: doc/aes_kexp_seq.md
Name: aes_kexp_seq

Overview:
- Sequencer for the 4-word XOR-chain key-expansion datapath.
- Accepts a key through a valid/ready start handshake.
- Emits round 0 (the raw key), then ROUNDS successive expanded round keys, one per accepted output beat, with full backpressure.
- Sits between a key-load source and a round-key consumer (cipher core or round-key buffer) and replaces free-running expansion with controlled stepping.

Parameters:
- WORD_W, 4: width of one key word; key/round-key width is 4*WORD_W.
- ROUNDS, 10: number of expansion steps after round 0; legal range 1..255.
- RND_W, $clog2(ROUNDS+1): width of the round index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_valid  in  1  key offered.
- start_ready  out  1  block can accept a key; high only in IDLE.
- key  in  4*WORD_W  key; word0 = MS word, word3 = LS word.
- abort  in  1  synchronous cancel of the current sequence.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts round key.
- rk_data  out  4*WORD_W  {w0,w1,w2,w3}.
- rk_round  out  RND_W  index of the round key on rk_data, 0..ROUNDS.
- busy  out  1  high in EMIT and DONE.
- done  out  1  one-cycle pulse after the last round key is accepted.

Behaviour:
- States: IDLE, EMIT, DONE. Encoding lives in the package.
- Reset (rst high at a clk edge):
  - State goes to IDLE; w0..w3 = 0; round counter = 0.
  - Outputs after reset: rk_valid=0, done=0, busy=0, start_ready=1, rk_data=0, rk_round=0.
  - Reset mid-sequence discards the sequence; no done pulse.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready: w0..w3 <= key slices, rnd <= 0, go to EMIT.
  - Latency: key accepted at edge T, rk_valid=1 from cycle T+1.
- EMIT:
  - rk_valid=1, rk_data={w0..w3}, rk_round=rnd.
  - While !rk_ready: all outputs held stable; no state change.
  - On rk_ready and rnd<ROUNDS: one expansion step, rnd++, stay in EMIT. Back-to-back beats at full rate are allowed.
  - On rk_ready and rnd==ROUNDS: go to DONE; w is not stepped.
- Expansion step (all terms from pre-step values, simultaneous):
  - w0' = w0
  - w1' = w0^w1
  - w2' = w0^w1^w2
  - w3' = w0^w1^w2^w3
- DONE: done=1 for exactly one cycle, rk_valid=0, then IDLE. start_ready is 0 in DONE, so a new key is taken no earlier than 2 cycles after the last beat.
- abort:
  - In EMIT or DONE: next state IDLE, rk_valid drops next cycle, no done pulse. w and rnd keep their values but are don't-care.
  - abort with rk_ready in the same cycle: abort wins; the beat on rk_data that cycle is still counted as transferred by the consumer.
  - abort in IDLE: no effect; if start_valid is also high, start wins.
- start_valid outside IDLE is ignored; the key is not captured.
- rst has priority over abort and start.
- Total accepted beats per sequence = ROUNDS+1, with rk_round running 0..ROUNDS with no gaps or repeats.
- Counter never wraps: the ROUNDS check precedes increment.

Decomposition:
- Shared package aes_kexp_pkg:
  - state enum (IDLE, EMIT, DONE);
  - WORD_W/ROUNDS defaults;
  - function kexp_step(words) returning the next 4-word set.
- One sub-module: aes_kexp_step_reg. It holds w0..w3, with load (from key) and step enables, and is purely the datapath register plus XOR chain.
- The FSM, round counter and handshake stay in aes_kexp_seq.

Test Plan:
- Reset then idle: hold rst 2 cycles -> start_ready=1, rk_valid=0, busy=0, done=0, rk_data=0.
- Key 16'h1234, rk_ready held 1, ROUNDS=10:
  - rk_data sequence starts 16'h1234 (round 0), 16'h1304 (round 1), 16'h1226 (round 2), ...;
  - 11 beats on consecutive cycles, rk_round 0..10;
  - done pulses one cycle after the round-10 beat.
- Key 16'hFFFF with random rk_ready stalls:
  - 16'hFFFF, then 16'hF0F0, then 16'hFF00 in order;
  - rk_data and rk_round stable during every stall;
  - no beat lost or duplicated.
- abort after round 3 accepted, while round 4 is pending:
  - next cycle rk_valid=0, start_ready=1;
  - no done pulse;
  - a new start with 16'h1234 restarts at round 0 = 16'h1234.
- start_valid asserted throughout a sequence with key 16'hAAAA:
  - ignored until IDLE;
  - captured exactly once, 2 cycles after the last beat;
  - first beat of the new sequence = 16'hAAAA.
- rst asserted mid-EMIT together with abort and rk_ready: next cycle all outputs at reset values, no done pulse.
